// File: rtl/seg7_read.sv
// seg7_read: reads a 7-segment + DP pattern back into a hex digit once it
// has been steady for STABLE_CYC samples.
// Ports: CLK clock, RES sync active-high reset, y[1:8] segments a..g + DP,
//   C polarity (1 = lit segment is 0), A digit, DP point, VALID strobe,
//   ERR illegal-pattern level.
// Optional: define SEG7_READ_BLANK_EN to accept all-unlit a..g as "blank".
module seg7_read #(
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic [1:8] y,
  input  logic       C,
  output logic [3:0] A,
  output logic       DP,
  output logic       VALID,
  output logic       ERR
);

  typedef enum logic [1:0] {
    SETTLE,
    DECIDE,
    HOLD
  } state_t;

  localparam logic [7:0] PRE = 8'(STABLE_CYC - 2);
  localparam logic [7:0] SAT = 8'(STABLE_CYC);

  // {C, y}; y[1] lands in bit 7
  logic [8:0] samp;
  logic [8:0] prev;
  logic [7:0] cnt;
  state_t     state;
  logic [8:0] last;
  logic       last_ok;

  logic       changed;
  logic [7:0] norm;
  logic [6:0] seg;
  logic       dp_n;
  logic [8:0] key;
  logic [3:0] digit;
  logic       is_digit;
  logic       legal;

  assign changed = (samp != prev);
  assign norm    = samp[7:0] ^ {8{samp[8]}};
  assign seg     = norm[7:1];
  assign dp_n    = norm[0];
  assign key     = {samp[8], norm};

  // seg is {a,b,c,d,e,f,g}
  always_comb begin
    digit    = 4'h0;
    is_digit = 1'b1;
    case (seg)
      7'b1111110: digit = 4'h0;
      7'b0110000: digit = 4'h1;
      7'b1101101: digit = 4'h2;
      7'b1111001: digit = 4'h3;
      7'b0110011: digit = 4'h4;
      7'b1011011: digit = 4'h5;
      7'b1011111: digit = 4'h6;
      7'b1110000: digit = 4'h7;
      7'b1111111: digit = 4'h8;
      7'b1111011: digit = 4'h9;
      7'b1110111: digit = 4'hA;
      7'b0011111: digit = 4'hB;
      7'b1001110: digit = 4'hC;
      7'b0111101: digit = 4'hD;
      7'b1001111: digit = 4'hE;
      7'b1000111: digit = 4'hF;
      default:    is_digit = 1'b0;
    endcase
  end

`ifdef SEG7_READ_BLANK_EN
  assign legal = is_digit | (seg == 7'b0);
`else
  assign legal = is_digit;
`endif

  // The decision is registered on the edge that enters DECIDE, so the
  // VALID strobe coincides with the DECIDE cycle.
  always_ff @(posedge CLK) begin
    if (RES) begin
      samp    <= '0;
      prev    <= '0;
      cnt     <= '0;
      state   <= SETTLE;
      last    <= '0;
      last_ok <= 1'b0;
      A       <= 4'h0;
      DP      <= 1'b0;
      VALID   <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      samp  <= {C, y};
      prev  <= samp;
      VALID <= 1'b0;
      if (changed) begin
        cnt   <= '0;
        state <= SETTLE;
      end else begin
        if (cnt != SAT)
          cnt <= cnt + 8'd1;
        case (state)
          SETTLE: begin
            if (cnt == PRE) begin
              state <= DECIDE;
              if (legal) begin
                if (!last_ok || last != key) begin
                  if (is_digit)
                    A <= digit;
                  DP      <= dp_n;
                  VALID   <= 1'b1;
                  ERR     <= 1'b0;
                  last    <= key;
                  last_ok <= 1'b1;
                end
              end else begin
                ERR     <= 1'b1;
                last_ok <= 1'b0;
              end
            end
          end
          DECIDE:  state <= HOLD;
          HOLD:    state <= HOLD;
          default: state <= SETTLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg7_read.sv
// tb_seg7_read: scoreboard bench for seg7_read.
// Expected VALID events are queued at stimulus time and popped on VALID.
module tb_seg7_read;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic [1:8] y   = 8'b1111_1100;
  logic       c   = 1'b0;
  logic [3:0] a;
  logic       dp;
  logic       valid;
  logic       err;

  int tests = 0;
  int fails = 0;
  int vcount = 0;

  typedef struct {
    logic [3:0] a;
    logic       dp;
  } exp_t;

  exp_t q[$];

  logic [6:0] seg_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  seg7_read #(.STABLE_CYC(S)) dut (
    .CLK  (clk),
    .RES  (res),
    .y    (y),
    .C    (c),
    .A    (a),
    .DP   (dp),
    .VALID(valid),
    .ERR  (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      exp_t e;
      vcount++;
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL valid_unexpected: got A=%0h DP=%0b, want no VALID",
                 a, dp);
      end else begin
        e = q.pop_front();
        if (a !== e.a || dp !== e.dp) begin
          fails++;
          $display("FAIL valid_data: got A=%0h DP=%0b, want A=%0h DP=%0b",
                   a, dp, e.a, e.dp);
        end
      end
    end
  end

  function automatic logic [1:8] enc(input logic [3:0] d,
                                     input logic dpv,
                                     input logic cc);
    logic [6:0] s;
    s = seg_tab[d];
    return {s, dpv} ^ {8{cc}};
  endfunction

  task automatic push(input logic [3:0] av, input logic dv);
    exp_t e;
    e.a  = av;
    e.dp = dv;
    q.push_back(e);
  endtask

  task automatic drive(input logic cc, input logic [1:8] yy);
    @(posedge clk);
    #1;
    c = cc;
    y = yy;
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic test_reset;
    int v0;
    hold(2);
    @(negedge clk);
    tests += 4;
    if (a !== 4'h0) begin
      fails++; $display("FAIL reset_a: got %0h want 0", a);
    end
    if (dp !== 1'b0) begin
      fails++; $display("FAIL reset_dp: got %0b want 0", dp);
    end
    if (valid !== 1'b0) begin
      fails++; $display("FAIL reset_valid: got %0b want 0", valid);
    end
    if (err !== 1'b0) begin
      fails++; $display("FAIL reset_err: got %0b want 0", err);
    end
    v0 = vcount;
    push(4'h0, 1'b0);
    res = 1'b0;
    hold(10);
    @(negedge clk);
    tests += 3;
    if (vcount - v0 != 1) begin
      fails++; $display("FAIL digit0_count: got %0d want 1", vcount - v0);
    end
    if (err !== 1'b0) begin
      fails++; $display("FAIL digit0_err: got %0b want 0", err);
    end
    if (q.size() != 0) begin
      fails++; $display("FAIL digit0_pending: got %0d want 0", q.size());
    end
  endtask

  task automatic test_latency;
    push(4'h1, 1'b1);
    drive(1'b1, 8'b1001_1110);
    for (int k = 0; k <= S; k++) begin
      @(posedge clk);
      @(negedge clk);
      tests++;
      if (valid !== (k == S)) begin
        fails++;
        $display("FAIL latency_edge%0d: got VALID=%0b want %0b",
                 k, valid, (k == S));
      end
    end
    hold(2);
    @(negedge clk);
    tests += 2;
    if (a !== 4'h1 || dp !== 1'b1) begin
      fails++; $display("FAIL digit1: got A=%0h DP=%0b want 1/1", a, dp);
    end
    if (valid !== 1'b0) begin
      fails++; $display("FAIL digit1_strobe: got %0b want 0", valid);
    end
  endtask

  task automatic test_glitch;
    int v0;
    push(4'h3, 1'b0);
    drive(1'b0, enc(4'h3, 1'b0, 1'b0));
    hold(S + 3);
    v0 = vcount;
    for (int g = 1; g < S; g++) begin
      drive(1'b0, enc(4'h8, 1'b0, 1'b0));
      hold(g - 1);
      drive(1'b0, enc(4'h3, 1'b0, 1'b0));
      hold(S + 3);
    end
    @(negedge clk);
    tests += 3;
    if (vcount != v0) begin
      fails++; $display("FAIL glitch_valid: got %0d want 0", vcount - v0);
    end
    if (a !== 4'h3) begin
      fails++; $display("FAIL glitch_a: got %0h want 3", a);
    end
    if (err !== 1'b0) begin
      fails++; $display("FAIL glitch_err: got %0b want 0", err);
    end
  endtask

  task automatic test_illegal;
    int v0;
    v0 = vcount;
    drive(1'b0, 8'b1000_0010);
    hold(S + 3);
    @(negedge clk);
    tests += 3;
    if (err !== 1'b1) begin
      fails++; $display("FAIL illegal_err: got %0b want 1", err);
    end
    if (vcount != v0) begin
      fails++; $display("FAIL illegal_valid: got %0d want 0", vcount - v0);
    end
    if (a !== 4'h3) begin
      fails++; $display("FAIL illegal_a: got %0h want 3", a);
    end
    // last accepted was invalidated, so the same digit 3 reports again
    push(4'h3, 1'b0);
    drive(1'b0, enc(4'h3, 1'b0, 1'b0));
    hold(S + 3);
    push(4'h5, 1'b0);
    drive(1'b0, enc(4'h5, 1'b0, 1'b0));
    hold(S + 3);
    @(negedge clk);
    tests += 3;
    if (a !== 4'h5) begin
      fails++; $display("FAIL recover_a: got %0h want 5", a);
    end
    if (err !== 1'b0) begin
      fails++; $display("FAIL recover_err: got %0b want 0", err);
    end
    if (vcount - v0 != 2) begin
      fails++; $display("FAIL recover_count: got %0d want 2", vcount - v0);
    end
  endtask

  task automatic test_reset_abort;
    int v0;
    v0 = vcount;
    drive(1'b0, enc(4'h9, 1'b0, 1'b0));
    hold(S);
    #1;
    res = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests += 5;
    if (vcount != v0) begin
      fails++; $display("FAIL abort_valid: got %0d want 0", vcount - v0);
    end
    if (a !== 4'h0 || dp !== 1'b0) begin
      fails++; $display("FAIL abort_out: got A=%0h DP=%0b want 0/0", a, dp);
    end
    if (valid !== 1'b0) begin
      fails++; $display("FAIL abort_strobe: got %0b want 0", valid);
    end
    if (err !== 1'b0) begin
      fails++; $display("FAIL abort_err: got %0b want 0", err);
    end
    if (q.size() != 0) begin
      fails++; $display("FAIL abort_pending: got %0d want 0", q.size());
    end
    push(4'h9, 1'b0);
    res = 1'b0;
    hold(10);
    @(negedge clk);
    tests += 2;
    if (vcount - v0 != 1) begin
      fails++; $display("FAIL after_abort: got %0d want 1", vcount - v0);
    end
    if (a !== 4'h9) begin
      fails++; $display("FAIL after_abort_a: got %0h want 9", a);
    end
  endtask

  task automatic test_back_to_back;
    logic cc;
    logic dv;
    for (int i = 0; i < 16; i++) begin
      cc = i[0];
      dv = i[1];
      push(4'(i), dv);
      drive(cc, enc(4'(i), dv, cc));
      hold(S + 2);
    end
    @(negedge clk);
    tests += 2;
    if (q.size() != 0) begin
      fails++; $display("FAIL b2b_pending: got %0d want 0", q.size());
    end
    if (a !== 4'hF) begin
      fails++; $display("FAIL b2b_last: got %0h want F", a);
    end
  endtask

  task automatic test_blank;
    int v0;
    v0 = vcount;
`ifdef SEG7_READ_BLANK_EN
    push(4'hF, 1'b1);
`endif
    drive(1'b0, 8'b0000_0001);
    hold(S + 3);
    @(negedge clk);
    tests += 3;
    if (a !== 4'hF) begin
      fails++; $display("FAIL blank_a: got %0h want F", a);
    end
`ifdef SEG7_READ_BLANK_EN
    if (err !== 1'b0 || dp !== 1'b1) begin
      fails++; $display("FAIL blank_on: got ERR=%0b DP=%0b want 0/1", err, dp);
    end
    if (vcount - v0 != 1) begin
      fails++; $display("FAIL blank_on_valid: got %0d want 1", vcount - v0);
    end
`else
    if (err !== 1'b1 || dp !== 1'b1) begin
      fails++;
      $display("FAIL blank_off: got ERR=%0b DP=%0b want 1/1", err, dp);
    end
    if (vcount != v0) begin
      fails++; $display("FAIL blank_off_valid: got %0d want 0", vcount - v0);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_latency;
    test_glitch;
    test_illegal;
    test_reset_abort;
    test_back_to_back;
    test_blank;
    hold(3);
    @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++; $display("FAIL final_pending: got %0d want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg7_read.md
SEG7_READ -- requirements
Module: seg7_read

Interface
REQ-001 Parameter STABLE_CYC, default 4, SHALL set the consecutive identical samples needed to accept a pattern; legal range 2..255.
REQ-002 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 RES  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 y  input  [1:8]  SHALL carry segment lines: y[1..7] = segments a..g, y[8] = DP.
REQ-005 C  input  1  SHALL select segment polarity: 0 = lit segment is 1; 1 = lit segment is 0.
REQ-006 A  output  [3:0]  SHALL hold the last accepted hex digit.
REQ-007 DP  output  1  SHALL hold the last accepted decimal-point state (1 = lit).
REQ-008 VALID  output  1  SHALL be a one-cycle strobe on each newly accepted digit.
REQ-009 ERR  output  1  SHALL be a level that is 1 while the last stable pattern is not a legal digit.

Function
REQ-010 {C, y} SHALL be registered once per cycle (sample stage); all logic uses the registered sample.
REQ-011 Lit segments SHALL be derived as y XOR {8{C}}, giving a normalized pattern.
REQ-012 Stability counter (8 bit) SHALL clear when the sample differs from the previous sample, else increment, saturating at STABLE_CYC.
REQ-013 FSM states SHALL be SETTLE (counting), DECIDE (one cycle at count == STABLE_CYC-1) and HOLD (pattern resolved, waiting for a change).
REQ-014 Transitions SHALL be: SETTLE->DECIDE when the count reaches STABLE_CYC-1; DECIDE->HOLD unconditionally; HOLD->SETTLE on any sample change; any state->SETTLE on a sample change.
REQ-015 The legal a..g sets SHALL be: 0 abcdef, 1 bc, 2 abdeg, 3 abcdg, 4 bcfg, 5 acdfg, 6 acdefg, 7 abc, 8 abcdefg, 9 abcdfg, A abcefg, b cdefg, C adef, d bcdeg, E adefg, F aefg.
REQ-016 In DECIDE with a legal pattern, if {C, pattern} differs from the last accepted value, the block SHALL update A and DP, pulse VALID for exactly that cycle and clear ERR.
REQ-017 In DECIDE with a legal pattern equal to the last accepted value, there SHALL be no VALID pulse, and A, DP and ERR SHALL be unchanged.
REQ-018 In DECIDE with an illegal pattern, the block SHALL set ERR, keep A and DP, produce no VALID, and invalidate the last accepted value.
REQ-019 Latency: a pattern that is present on y from edge n and held steady SHALL produce VALID during the cycle after edge n+STABLE_CYC.
REQ-020 A glitch shorter than STABLE_CYC samples SHALL produce no VALID and no ERR change.
REQ-021 A change of C alone SHALL count as a sample change and restart settling.
REQ-022 DP SHALL be taken from the pattern but SHALL NOT affect legality.

Reset
REQ-023 RES=1 at a rising edge SHALL set A=0, DP=0, VALID=0, ERR=0, counter=0, state=SETTLE, and last accepted = invalid, so the first stable legal pattern is always reported.
REQ-024 RES asserted mid-settle or during DECIDE SHALL abort that decision with no VALID pulse.
REQ-025 The sample register SHALL also reset, to all zeros.

Configuration
REQ-026 Macro SEG7_READ_BLANK_EN SHALL control blank-pattern handling.
REQ-027 With SEG7_READ_BLANK_EN defined, an all-unlit a..g pattern SHALL be legal as "blank": ERR=0, A held, DP updated, and VALID pulsed on a change from the last accepted value.
REQ-028 Without SEG7_READ_BLANK_EN, an all-unlit a..g pattern SHALL be illegal and handled per REQ-018.

Verification
REQ-029 Reset, then C=0 and y=8'b1111_1100 (digit 0, DP off) held 10 cycles -> exactly one VALID, A=0, DP=0, ERR=0.
REQ-030 C=1 and y=8'b1001_1110 (digit 1, DP lit) held -> one VALID after STABLE_CYC+1 edges, A=1, DP=1.
REQ-031 Stable digit 3, then a 2-cycle glitch to digit 8, then back to 3 -> no VALID and A stays 3.
REQ-032 C=0 and y=8'b1000_0010 (illegal) held -> ERR=1, no VALID, A unchanged; then digit 5 held -> VALID, A=5, ERR=0.
REQ-033 RES pulsed at count STABLE_CYC-2 during settling -> no VALID, all outputs 0; the same pattern still held afterwards -> one VALID.
REQ-034 All-unlit pattern held -> ERR=0 and VALID with the macro defined; ERR=1 and no VALID without it.
